// File: rtl/bf16_mult_arbiter_if.sv
// Request, multiplier and response bus of the shared BF16 multiplier arbiter.
// The master modport is the environment side (requesters, multiplier, consumer).
interface bf16_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    REQ_VALID;
  logic [NUM_REQ-1:0]    REQ_READY;
  logic [16*NUM_REQ-1:0] REQ_A;
  logic [16*NUM_REQ-1:0] REQ_B;
  logic [15:0]           MUL_A;
  logic [15:0]           MUL_B;
  logic [31:0]           MUL_O;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [31:0]           RSP_O;
  logic [ID_W-1:0]       RSP_ID;

  modport master (
    output REQ_VALID, REQ_A, REQ_B, MUL_O, RSP_READY,
    input  REQ_READY, MUL_A, MUL_B, RSP_VALID, RSP_O, RSP_ID
  );

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, MUL_O, RSP_READY,
    output REQ_READY, MUL_A, MUL_B, RSP_VALID, RSP_O, RSP_ID
  );
endinterface

// File: rtl/bf16_mult_arbiter.sv
// Round-robin arbiter sharing one registered BF16 multiplier, with ID tagging and a credited output FIFO.
// Optional macro BF16_MULT_ARB_PERF_EN adds PERF_BUSY / PERF_STALL saturating counters.
module bf16_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MUL_LAT   = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  bf16_mult_arbiter_if.slave  bus
`ifdef BF16_MULT_ARB_PERF_EN
  ,
  output logic [31:0]         PERF_BUSY,
  output logic [31:0]         PERF_STALL
`endif
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int ENT_W = ID_W + 32;

  logic [ID_W-1:0]    rr_ptr_r;
  logic [MUL_LAT-1:0] pipe_vld_r;
  logic [ID_W-1:0]    pipe_id_r [MUL_LAT];
  logic [ENT_W-1:0]   fifo_mem_r [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   fifo_cnt_r;
  logic               rsp_valid_r;
  logic [31:0]        rsp_o_r;
  logic [ID_W-1:0]    rsp_id_r;

  logic [CNT_W:0]     inflight_s;
  logic [CNT_W:0]     credit_used_s;
  logic               issue_ok_s;
  logic               any_req_s;
  logic               hi_found_s;
  logic [ID_W-1:0]    hi_idx_s;
  logic [ID_W-1:0]    lo_idx_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               hs_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [15:0]        mul_a_s;
  logic [15:0]        mul_b_s;
  logic               push_s;
  logic               pop_s;
  logic [ENT_W-1:0]   push_ent_s;
  logic [ENT_W-1:0]   head_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]   cnt_after_pop_s;
  logic [CNT_W-1:0]   fifo_cnt_nxt_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Credit check: a result slot is reserved from issue until it is popped.
  always_comb begin
    inflight_s = {(CNT_W+1){1'b0}};
    for (int i = 0; i < MUL_LAT; i++) begin
      inflight_s = inflight_s + (CNT_W+1)'(pipe_vld_r[i]);
    end
    credit_used_s = inflight_s + {1'b0, fifo_cnt_r};
    issue_ok_s    = (credit_used_s < (CNT_W+1)'(OUT_DEPTH)) && !RST;
  end

  // Round-robin pick: lowest valid index above the pointer, else lowest valid index overall.
  always_comb begin
    any_req_s  = 1'b0;
    hi_found_s = 1'b0;
    hi_idx_s   = {ID_W{1'b0}};
    lo_idx_s   = {ID_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.REQ_VALID[i]) begin
        any_req_s = 1'b1;
        lo_idx_s  = ID_W'(i);
        if (ID_W'(i) > rr_ptr_r) begin
          hi_found_s = 1'b1;
          hi_idx_s   = ID_W'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        any_req_s = any_req_s;
      end
    end
    gnt_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
    hs_s      = issue_ok_s && any_req_s;
  end

  // One-hot ready and operand steering for the granted requester.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    mul_a_s     = 16'h0000;
    mul_b_s     = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs_s && (gnt_idx_s == ID_W'(i))) begin
        req_ready_s[i] = 1'b1;
        mul_a_s        = bus.REQ_A[16*i +: 16];
        mul_b_s        = bus.REQ_B[16*i +: 16];
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  assign bus.REQ_READY = req_ready_s;
  assign bus.MUL_A     = mul_a_s;
  assign bus.MUL_B     = mul_b_s;

  // FIFO next-state; the head register is refilled from the pushed entry when the FIFO would otherwise be empty.
  always_comb begin
    push_s          = pipe_vld_r[MUL_LAT-1];
    push_ent_s      = {pipe_id_r[MUL_LAT-1], bus.MUL_O};
    pop_s           = bus.RSP_READY && (fifo_cnt_r != {CNT_W{1'b0}});
    wr_ptr_nxt_s    = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    rd_ptr_nxt_s    = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    cnt_after_pop_s = fifo_cnt_r - CNT_W'(pop_s);
    fifo_cnt_nxt_s  = cnt_after_pop_s + CNT_W'(push_s);
    head_nxt_s      = (cnt_after_pop_s == {CNT_W{1'b0}}) ? push_ent_s : fifo_mem_r[rd_ptr_nxt_s];
  end

  // Arbitration pointer, tag pipeline, FIFO storage and registered response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_r    <= ID_W'(NUM_REQ - 1);
      pipe_vld_r  <= {MUL_LAT{1'b0}};
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_id_r[i] <= {ID_W{1'b0}};
      end
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      fifo_cnt_r  <= {CNT_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_o_r     <= 32'h0000_0000;
      rsp_id_r    <= {ID_W{1'b0}};
    end else begin
      if (hs_s) begin
        rr_ptr_r <= gnt_idx_s;
      end
      pipe_vld_r[0] <= hs_s;
      pipe_id_r[0]  <= gnt_idx_s;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_id_r[i]  <= pipe_id_r[i-1];
      end
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= push_ent_s;
      end
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      fifo_cnt_r  <= fifo_cnt_nxt_s;
      rsp_valid_r <= (fifo_cnt_nxt_s != {CNT_W{1'b0}});
      if (fifo_cnt_nxt_s != {CNT_W{1'b0}}) begin
        {rsp_id_r, rsp_o_r} <= head_nxt_s;
      end
    end
  end

  assign bus.RSP_VALID = rsp_valid_r;
  assign bus.RSP_O     = rsp_o_r;
  assign bus.RSP_ID    = rsp_id_r;

`ifdef BF16_MULT_ARB_PERF_EN
  logic [31:0] perf_busy_r;
  logic [31:0] perf_stall_r;

  // Saturating counts of issue cycles and of credit-starved request cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_busy_r  <= 32'h0000_0000;
      perf_stall_r <= 32'h0000_0000;
    end else begin
      if (hs_s && (perf_busy_r != 32'hFFFF_FFFF)) begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end
      if (any_req_s && !issue_ok_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign PERF_BUSY  = perf_busy_r;
  assign PERF_STALL = perf_stall_r;
`endif

endmodule

// File: tb/tb_bf16_mult_arbiter.sv
// Randomized bench for bf16_mult_arbiter against a transaction-queue reference model.
// The shared multiplier is modelled here as a registered exact BF16*BF16->FP32 product.
module tb_bf16_mult_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int ID_W      = 2;
  localparam int OUT_DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  bf16_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

`ifdef BF16_MULT_ARB_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  bf16_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(1), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef BF16_MULT_ARB_PERF_EN
    ,
    .PERF_BUSY(perf_busy),
    .PERF_STALL(perf_stall)
`endif
  );

  // Exact for normal operands: an 8x8-bit significand product always fits FP32.
  function automatic logic [31:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    int          e;
    logic [22:0] f;
    p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    e = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (p[15]) begin
      e = e + 1;
      f = {p[14:0], 8'd0};
    end else begin
      f = {p[13:0], 9'd0};
    end
    return {a[15] ^ b[15], e[7:0], f};
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] v;
    v = {1'($urandom_range(0, 1)), 8'($urandom_range(96, 158)), 7'($urandom_range(0, 127))};
    return v;
  endfunction

  logic [31:0] mul_o_r;
  always @(posedge CLK) mul_o_r <= bf16_mul(bus.MUL_A, bus.MUL_B);
  assign bus.MUL_O = mul_o_r;

  typedef struct {
    int          id;
    logic [31:0] prod;
    int          due;
  } txn_t;

  txn_t               exp_q[$];
  logic [NUM_REQ-1:0] want;
  logic [15:0]        op_a [NUM_REQ];
  logic [15:0]        op_b [NUM_REQ];
  int                 ptr_m;
  int                 cyc;
  int                 n_checks;
  int                 n_fail;
  int                 busy_m;
  int                 stall_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive after the edge, sample mid-cycle, then advance the reference model.
  task automatic cycle_step(input int p_valid, input int p_ready, input logic rst_in);
    int          gnt;
    logic        ok;
    logic        exp_rv;
    logic        rdy;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    @(posedge CLK);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!want[i] && (int'($urandom_range(0, 99)) < p_valid)) want[i] = 1'b1;
    end
    rdy = (int'($urandom_range(0, 99)) < p_ready);
    RST = rst_in;
    bus.REQ_VALID = want;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.REQ_A[16*i +: 16] = op_a[i];
      bus.REQ_B[16*i +: 16] = op_b[i];
    end
    bus.RSP_READY = rdy;
    #2;
    ok  = (exp_q.size() < OUT_DEPTH) && !rst_in;
    gnt = -1;
    if (ok) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int j;
        j = (ptr_m + k) % NUM_REQ;
        if (gnt < 0 && want[j]) gnt = j;
      end
    end
    exp_a = 32'd0;
    exp_b = 32'd0;
    if (gnt >= 0) begin
      exp_a = 32'(op_a[gnt]);
      exp_b = 32'(op_b[gnt]);
    end
    check("req_ready", 32'(bus.REQ_READY), (gnt >= 0) ? (32'd1 << gnt) : 32'd0);
    check("mul_a", 32'(bus.MUL_A), exp_a);
    check("mul_b", 32'(bus.MUL_B), exp_b);
    exp_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("rsp_valid", 32'(bus.RSP_VALID), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_o", bus.RSP_O, exp_q[0].prod);
      check("rsp_id", 32'(bus.RSP_ID), 32'(exp_q[0].id));
    end
    if (gnt >= 0) busy_m++;
    if ((|want) && !ok) stall_m++;
    if (exp_rv && rdy) void'(exp_q.pop_front());
    if (gnt >= 0) begin
      exp_q.push_back('{gnt, bf16_mul(op_a[gnt], op_b[gnt]), cyc + 2});
      ptr_m     = gnt;
      want[gnt] = 1'b0;
      op_a[gnt] = rand_bf16();
      op_b[gnt] = rand_bf16();
    end
    if (rst_in) begin
      exp_q.delete();
      ptr_m   = NUM_REQ - 1;
      busy_m  = 0;
      stall_m = 0;
    end
    cyc++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    busy_m   = 0;
    stall_m  = 0;
    ptr_m    = NUM_REQ - 1;
    want     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = rand_bf16();
      op_b[i] = rand_bf16();
    end
    bus.REQ_VALID = '0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.RSP_READY = 1'b0;

    cycle_step(0, 100, 1'b1);
    cycle_step(0, 100, 1'b1);
    check("rst_rsp_o", bus.RSP_O, 32'd0);
    check("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
    cycle_step(0, 100, 1'b0);

`ifdef BF16_MULT_ARB_PERF_EN
    // 4 issues fill the credits, 3 starved cycles, then 2 more issues as credits return.
    want = 4'b1111;
    repeat (4) cycle_step(0, 0, 1'b0);
    want[0] = 1'b1;
    cycle_step(0, 0, 1'b0);
    cycle_step(0, 0, 1'b0);
    cycle_step(0, 100, 1'b0);
    cycle_step(0, 100, 1'b0);
    want[1] = 1'b1;
    cycle_step(0, 100, 1'b0);
    repeat (8) cycle_step(0, 100, 1'b0);
    check("perf_busy_6", perf_busy, 32'd6);
    check("perf_stall_3", perf_stall, 32'd3);
    cycle_step(0, 100, 1'b1);
`endif

    // Single request from requester 2: 1.0 * 2.0.
    op_a[2] = 16'h3F80;
    op_b[2] = 16'h4000;
    want[2] = 1'b1;
    cycle_step(0, 100, 1'b0);
    cycle_step(0, 100, 1'b0);
    cycle_step(0, 100, 1'b0);
    check("single_rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    check("single_rsp_o", bus.RSP_O, 32'h4000_0000);
    check("single_rsp_id", 32'(bus.RSP_ID), 32'd2);
    repeat (2) cycle_step(0, 100, 1'b0);

    // Round-robin from a fresh reset.
    cycle_step(0, 100, 1'b1);
    repeat (8) cycle_step(100, 100, 1'b0);
    repeat (4) cycle_step(0, 100, 1'b0);

    // Backpressure then release with continuous issue.
    repeat (8) cycle_step(100, 0, 1'b0);
    check("bp_ready_zero", 32'(bus.REQ_READY), 32'd0);
    repeat (12) cycle_step(100, 100, 1'b0);
    repeat (6) cycle_step(0, 100, 1'b0);

    // Reset with products in flight and buffered.
    repeat (2) cycle_step(100, 100, 1'b0);
    cycle_step(100, 100, 1'b1);
    cycle_step(100, 100, 1'b0);
    check("post_rst_gnt0", 32'(bus.REQ_READY), 32'd1);
    repeat (4) cycle_step(0, 100, 1'b0);

    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      cycle_step(60, 70, ($urandom_range(0, 99) == 0));
    end
    repeat (8) cycle_step(0, 100, 1'b0);

`ifdef BF16_MULT_ARB_PERF_EN
    check("perf_busy_model", perf_busy, 32'(busy_m));
    check("perf_stall_model", perf_stall, 32'(stall_m));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
